phy_tx_sched: RTL

Two-requester scheduler that sits in front of the PCIe PHY transmit datapath and owns its 32-bit word input (`data_in`/`valid_in`). It arbitrates round-robin between two word sources at burst granularity and enforces a bounded burst length. It inserts a mandatory one-cycle gap between bursts. Its registered output drives the TX datapath directly in the `clk_2f` word-clock domain.

---
 rtl/phy_tx_pkg.sv | 13 +
 rtl/phy_tx_sched.sv | 122 ++++++++++++
 2 files changed

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PCIe PHY transmit scheduler.
package phy_tx_pkg;

    localparam int unsigned PHY_DATA_W = 32;
    localparam logic [PHY_DATA_W-1:0] IDLE_WORD_DEF = 32'hBCBC_BCBC;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } sched_state_e;

endpackage

// File: rtl/phy_tx_sched.sv
// Two-requester burst scheduler feeding the PHY TX datapath: round-robin at burst
// granularity, bounded burst length, one idle cycle between bursts, registered output.
module phy_tx_sched
    import phy_tx_pkg::*;
#(
    parameter int unsigned       DATA_W    = PHY_DATA_W,
    parameter int unsigned       MAX_BURST = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_src,
    output logic              tx_eop
);

    localparam int unsigned     CntW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    sched_state_e      state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_src_q, tx_src_d;
    logic              tx_eop_q, tx_eop_d;

    logic              sel_src;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              burst_end;

    // Only meaningful in a grant state; the owner is the requester being drained.
    assign sel_src   = (state_q == StGrant1);
    assign sel_valid = sel_src ? req1_valid : req0_valid;
    assign sel_last  = sel_src ? req1_last  : req0_last;
    assign sel_data  = sel_src ? req1_data  : req0_data;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        tx_data_d   = IDLE_WORD;
        tx_valid_d  = 1'b0;
        tx_src_d    = 1'b0;
        tx_eop_d    = 1'b0;
        burst_end   = 1'b0;

        unique case (state_q)
            StIdle: begin
                burst_cnt_d = '0;
                if (req0_valid && req1_valid) begin
                    state_d = rr_ptr_q ? StGrant1 : StGrant0;
                end else if (req0_valid) begin
                    state_d = StGrant0;
                end else if (req1_valid) begin
                    state_d = StGrant1;
                end
            end
            StGrant0, StGrant1: begin
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    tx_valid_d = 1'b1;
                    tx_src_d   = sel_src;
                    tx_eop_d   = sel_last || (burst_cnt_q == CntMax);
                    burst_end  = tx_eop_d;
                    if (!burst_end) begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end else begin
                    // Broken burst: no eop, the gap itself terminates it downstream.
                    burst_end = 1'b1;
                end
                if (burst_end) begin
                    state_d     = StIdle;
                    rr_ptr_d    = ~sel_src;
                    burst_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            tx_data_q   <= IDLE_WORD;
            tx_valid_q  <= 1'b0;
            tx_src_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_src_q    <= tx_src_d;
            tx_eop_q    <= tx_eop_d;
        end
    end

    assign req0_ready = (state_q == StGrant0);
    assign req1_ready = (state_q == StGrant1);

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_src   = tx_src_q;
    assign tx_eop   = tx_eop_q;

endmodule
